// File: rtl/spi_channel_router.sv
// SPI byte-stream router: header/length framing, payload FIFO shared by N_CH channels,
// response capture into tx_data, inactivity timeout and a free-running tick divider.
module spi_channel_router #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CLK_DIV        = 250,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic [7:0]          tx_data,
  output logic [7:0]          ch_dout,
  output logic [N_CH-1:0]     ch_valid,
  input  logic [N_CH-1:0]     ch_ready,
  input  logic [8*N_CH-1:0]   ch_din,
  input  logic [N_CH-1:0]     ch_din_valid,
  output logic [N_CH-1:0]     ch_start,
  output logic                tick,
  output logic                busy,
  output logic [3:0]          status
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned TickW = $clog2(CLK_DIV);

  localparam logic [CntW-1:0]  DepthC   = CntW'(FIFO_DEPTH);
  localparam logic [TickW-1:0] TickLast = TickW'(CLK_DIV - 1);
  localparam logic [31:0]      TmoLast  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       NChC     = 4'(N_CH);

  typedef enum logic [1:0] {StIdle, StLen, StXfer, StDrain} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [8:0]        remaining_q, remaining_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              bad_hdr_q, bad_hdr_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [N_CH-1:0]   ch_start_q, ch_start_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [31:0]       tmo_cnt_q, tmo_cnt_d;

  logic [7:0]        ready_pad, din_valid_pad;
  logic [63:0]       din_pad;
  logic              fifo_empty, pop, push, flush, tmo_fire, is_busy;
  logic [3:0]        status_d;

  // Channel-indexed inputs widened to 8 lanes so a 3-bit sel can index them directly.
  always_comb begin
    ready_pad                 = '0;
    ready_pad[N_CH-1:0]       = ch_ready;
    din_valid_pad             = '0;
    din_valid_pad[N_CH-1:0]   = ch_din_valid;
    din_pad                   = '0;
    din_pad[8*N_CH-1:0]       = ch_din;
  end

  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && ready_pad[sel_q];
  assign is_busy    = (state_q != StIdle);
  assign tmo_fire   = is_busy && (tmo_cnt_q == TmoLast) && !rx_valid && !pop;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    bad_hdr_d   = bad_hdr_q;
    timeout_d   = timeout_q;
    overflow_d  = overflow_q;
    ch_start_d  = '0;
    push        = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data[7:6] == 2'b11) begin
            if ({1'b0, rx_data[2:0]} < NChC) begin
              sel_d   = rx_data[2:0];
              state_d = StLen;
              for (int unsigned k = 0; k < N_CH; k++) begin
                ch_start_d[k] = (rx_data[2:0] == 3'(k));
              end
            end else begin
              bad_hdr_d = 1'b1;
            end
          end else if (rx_data[7:6] == 2'b10) begin
            bad_hdr_d  = 1'b0;
            timeout_d  = 1'b0;
            overflow_d = 1'b0;
          end
        end
      end
      StLen: begin
        if (rx_valid) begin
          remaining_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d     = StXfer;
        end
      end
      StXfer: begin
        if (rx_valid) begin
          // A full FIFO still accepts when the head leaves in the same cycle.
          if ((count_q < DepthC) || pop) begin
            push = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == 9'd1) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: ;
      default: state_d = StIdle;
    endcase

    if (tmo_fire) begin
      state_d   = StIdle;
      timeout_d = 1'b1;
      flush     = 1'b1;
    end

    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    if ((state_q == StDrain) && (count_d == '0)) begin
      state_d = StIdle;
    end

    status_d  = {bad_hdr_d, timeout_d, overflow_d, 1'b0};
    tx_data_d = tx_data_q;
    if (din_valid_pad[sel_q]) begin
      tx_data_d = din_pad[{sel_q, 3'b000} +: 8];
    end
    // While idle the master reads back the status flags.
    if ((state_d == StIdle) && ((state_q != StIdle) || (status_d != status))) begin
      tx_data_d = {4'h0, status_d};
    end

    tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);

    if ((state_q == StIdle) || rx_valid || pop) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bad_hdr_q   <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      tx_data_q   <= '0;
      ch_start_q  <= '0;
      tick_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bad_hdr_q   <= bad_hdr_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      tx_data_q   <= tx_data_d;
      ch_start_q  <= ch_start_d;
      tick_cnt_q  <= tick_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_comb begin
    ch_valid = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      ch_valid[k] = !fifo_empty && (sel_q == 3'(k));
    end
  end

  assign ch_dout  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign tx_data  = tx_data_q;
  assign ch_start = ch_start_q;
  assign tick     = (tick_cnt_q == TickLast);
  assign busy     = is_busy;
  assign status   = {bad_hdr_q, timeout_q, overflow_q, 1'b0};

endmodule

// File: tb/tb_spi_channel_router.sv
// Randomized scoreboard bench for spi_channel_router: frame-level reference model feeds
// expected payload/start queues; a negedge monitor pops and compares on every handshake.
module tb_spi_channel_router;

  localparam int NCh   = 4;
  localparam int Depth = 4;
  localparam int Div   = 250;
  localparam int Tmo   = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;
  logic [7:0]        ch_dout;
  logic [NCh-1:0]    ch_valid;
  logic [NCh-1:0]    ch_ready;
  logic [8*NCh-1:0]  ch_din;
  logic [NCh-1:0]    ch_din_valid;
  logic [NCh-1:0]    ch_start;
  logic              tick;
  logic              busy;
  logic [3:0]        status;

  spi_channel_router #(
    .N_CH(NCh), .FIFO_DEPTH(Depth), .CLK_DIV(Div), .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data),
    .ch_dout(ch_dout), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_din(ch_din),
    .ch_din_valid(ch_din_valid), .ch_start(ch_start), .tick(tick), .busy(busy),
    .status(status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] b;
  } pay_t;

  pay_t       exp_pay[$];
  logic [3:0] exp_start[$];
  int         checks = 0;
  int         failures = 0;
  int         start_seen = 0;
  logic [3:0] m_status = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every start pulse and every payload handshake against the queues.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (ch_start != '0) begin
        start_seen++;
        if (exp_start.size() == 0) chk("start_unexpected", 32'(ch_start), 32'h0);
        else chk("ch_start", 32'(ch_start), 32'(exp_start.pop_front()));
      end
      if (ch_valid != '0) chk("valid_onehot", 32'($countones(ch_valid)), 32'd1);
      if ((ch_valid & ch_ready) != '0) begin
        int idx;
        pay_t e;
        idx = 0;
        for (int k = 0; k < NCh; k++) if (ch_valid[k] && ch_ready[k]) idx = k;
        if (exp_pay.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got ch%0d data %0h expected no pop", idx, ch_dout);
        end else begin
          e = exp_pay.pop_front();
          chk("pop_ch", 32'(idx), 32'(e.ch));
          chk("pop_data", 32'(ch_dout), 32'(e.b));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      step(1);
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic check_idle_status(input string name);
    chk({name, "_status"}, 32'(status), 32'(m_status));
    chk({name, "_txdata"}, 32'(tx_data), {28'h0, m_status});
  endtask

  // Full frame; with ready held low only the first Depth bytes fit, the rest overflow.
  task automatic frame(input int ch, input logic [7:0] len_b, input bit ready_mode,
                       input bit junk, input bit rnd_gap);
    int n;
    logic [7:0] b;
    n = (len_b == 8'h00) ? 256 : int'(len_b);
    ch_ready = ready_mode ? NCh'(1 << ch) : '0;
    exp_start.push_back(4'(1 << ch));
    send(8'hC0 | 8'(ch));
    send(len_b);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (ready_mode || i < Depth) exp_pay.push_back('{ch: 3'(ch), b: b});
      else m_status[1] = 1'b1;
      send(b);
      if (rnd_gap) step($urandom_range(0, 2));
    end
    if (!ready_mode) begin
      if (junk) send(8'hEE);
      step(2);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_status", 32'(status), 32'(m_status));
      ch_ready = NCh'(1 << ch);
    end
    wait_idle(600, "frame_idle");
    step(1);
    chk("frame_queue_empty", 32'(exp_pay.size()), 32'd0);
    check_idle_status("frame");
  endtask

  initial begin
    int s0, kind, cnt;
    logic [7:0] h;
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    ch_ready     = '0;
    ch_din       = '0;
    ch_din_valid = '0;
    step(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(ch_valid), 32'd0);
    chk("rst_start", 32'(ch_start), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    reset = 1'b0;
    step(2);

    // Basic frame on channel 2 with fixed payload.
    s0 = start_seen;
    ch_ready = 4'b0100;
    exp_start.push_back(4'b0100);
    send(8'hC2);
    send(8'h03);
    exp_pay.push_back('{ch: 3'd2, b: 8'h11}); send(8'h11);
    exp_pay.push_back('{ch: 3'd2, b: 8'h22}); send(8'h22);
    exp_pay.push_back('{ch: 3'd2, b: 8'h33}); send(8'h33);
    wait_idle(20, "f1_idle");
    chk("f1_start_once", 32'(start_seen - s0), 32'd1);
    chk("f1_queue_empty", 32'(exp_pay.size()), 32'd0);

    // Bad header then clear.
    send(8'hC7);
    m_status[3] = 1'b1;
    chk("badhdr_busy", 32'(busy), 32'd0);
    chk("badhdr_status", 32'(status), 32'h8);
    chk("badhdr_txdata", 32'(tx_data), 32'h08);
    send(8'h80);
    m_status = 4'h0;
    chk("clear_status", 32'(status), 32'h0);
    chk("clear_txdata", 32'(tx_data), 32'h00);

    // Response capture: only the selected slice is taken.
    ch_ready = '0;
    exp_start.push_back(4'b0010);
    send(8'hC1);
    ch_din       = {8'h00, 8'h00, 8'h55, 8'hAA};
    ch_din_valid = 4'b0011;
    step(1);
    ch_din_valid = '0;
    chk("resp_sel", 32'(tx_data), 32'h55);
    ch_din       = {8'h99, 8'h77, 8'h55, 8'hCC};
    ch_din_valid = 4'b1101;
    step(1);
    ch_din_valid = '0;
    chk("resp_ignore", 32'(tx_data), 32'h55);
    ch_ready = 4'b0010;
    send(8'h01);
    exp_pay.push_back('{ch: 3'd1, b: 8'h5A}); send(8'h5A);
    wait_idle(20, "resp_idle");
    check_idle_status("resp");

    // Overflow with ready low, plus a junk byte while draining.
    frame(1, 8'h06, 1'b0, 1'b1, 1'b0);

    // Inactivity timeout: exactly Tmo quiet cycles.
    ch_ready = '0;
    exp_start.push_back(4'b0001);
    send(8'hC0);
    send(8'h05);
    exp_pay.push_back('{ch: 3'd0, b: 8'hA1}); send(8'hA1);
    exp_pay.push_back('{ch: 3'd0, b: 8'hA2}); send(8'hA2);
    step(Tmo - 1);
    chk("tmo_not_early", 32'(busy), 32'd1);
    step(1);
    chk("tmo_fire", 32'(busy), 32'd0);
    exp_pay.delete();
    m_status[2] = 1'b1;
    chk("tmo_valid", 32'(ch_valid), 32'd0);
    step(1);
    check_idle_status("tmo");

    // Length byte 0 means 256 payload bytes.
    frame(3, 8'h00, 1'b1, 1'b0, 1'b0);

    // Randomized mix of frames and headers.
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 6);
      if (kind <= 3) begin
        frame($urandom_range(0, NCh - 1), 8'($urandom_range(1, 7)), 1'($urandom), 1'b0, 1'b1);
      end else if (kind == 4) begin
        h = 8'hC0 | 8'($urandom_range(NCh, 7)) | (8'($urandom_range(0, 7)) << 3);
        send(h);
        m_status[3] = 1'b1;
        chk("rnd_bad_busy", 32'(busy), 32'd0);
        check_idle_status("rnd_bad");
      end else if (kind == 5) begin
        send(8'h80 | 8'($urandom_range(0, 63)));
        m_status = 4'h0;
        check_idle_status("rnd_clr");
      end else begin
        send(8'($urandom_range(0, 127)));
        chk("rnd_ign_busy", 32'(busy), 32'd0);
        check_idle_status("rnd_ign");
      end
    end

    // Tick period.
    cnt = 0;
    while (!tick && cnt < 2 * Div) begin
      @(negedge clk);
      cnt++;
    end
    chk("tick_found", 32'(tick), 32'd1);
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!tick && cnt < 2 * Div);
      chk("tick_period", 32'(cnt), 32'(Div));
    end
    step(1);

    // Reset in the middle of a frame.
    ch_ready = '0;
    exp_start.push_back(4'b1000);
    send(8'hC3);
    send(8'h08);
    for (int i = 0; i < 3; i++) begin
      h = 8'($urandom);
      exp_pay.push_back('{ch: 3'd3, b: h});
      send(h);
    end
    step(2);
    chk("mid_valid", 32'(ch_valid), 32'h8);
    reset = 1'b1;
    exp_pay.delete();
    exp_start.delete();
    m_status = 4'h0;
    step(1);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_valid", 32'(ch_valid), 32'd0);
    chk("rst2_start", 32'(ch_start), 32'd0);
    chk("rst2_tick", 32'(tick), 32'd0);
    chk("rst2_status", 32'(status), 32'd0);
    chk("rst2_txdata", 32'(tx_data), 32'd0);
    chk("rst2_dout", 32'(ch_dout), 32'd0);
    reset = 1'b0;
    ch_ready = 4'b1000;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ch_valid != '0 || ch_start != '0 || busy) cnt++;
    end
    chk("post_rst_quiet", 32'(cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
